// File: rtl/regfile_pkg.sv
// Shared register-file constants and the arbitration pointer type.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int R0_ADDR  = 0;

    // Names the port that wins the next contended cycle.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    // Returns the port that is not p.
    function automatic port_e other_port(input port_e p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin grant. The pointer only moves when both requests are
// present, so a lone requester never disturbs the fairness order.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      ptr,
    output logic [1:0] grant,
    output port_e      ptr_next
);

    // One-hot grant and next pointer from the requests and current pointer.
    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                grant    = (ptr == PORT0) ? 2'b01 : 2'b10;
                ptr_next = other_port(ptr);
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port
// and keeps a per-register pending-write scoreboard.
//
// Handshake: a port transfers in any cycle where its valid and ready are both
// high. Ready is combinational from the valids and the priority pointer, at
// most one ready is high per cycle, and both readys are held low during reset.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        rc,
    output logic [DATA_W-1:0]        wd,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic                     r0_err
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(R0_ADDR);

    logic [1:0]              req;
    logic [1:0]              grant;
    port_e                   ptr;
    port_e                   ptr_next;
    logic                    xfer_valid;
    logic [ADDR_W-1:0]       xfer_addr;
    logic [DATA_W-1:0]       xfer_data;
    logic                    xfer_is_r0;
    logic                    wr_issue;
    logic [(2**ADDR_W)-1:0]  busy_next;

    // Requests are masked during reset so nothing is accepted then.
    assign req = {req1_valid & ~rst, req0_valid & ~rst};

    rr_arbiter2 u_arb (
        .req      (req),
        .ptr      (ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Select the address and data of whichever port transfers this cycle.
    always_comb begin
        xfer_valid = |grant;
        xfer_addr  = grant[1] ? req1_addr : req0_addr;
        xfer_data  = grant[1] ? req1_data : req0_data;
        xfer_is_r0 = (xfer_addr == ZERO_ADDR);
        wr_issue   = xfer_valid & ~xfer_is_r0;
    end

    // Scoreboard update: clear on the issued write, then set on reserve so a
    // same-cycle reserve wins; register 0 never reads as busy.
    always_comb begin
        busy_next = busy;
        if (RegWrite) begin
            busy_next[rc] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != ZERO_ADDR)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Pointer, write-port registers, scoreboard and sticky r0 error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= PORT0;
            RegWrite <= 1'b0;
            rc       <= '0;
            wd       <= '0;
            busy     <= '0;
            r0_err   <= 1'b0;
        end else begin
            ptr      <= ptr_next;
            RegWrite <= wr_issue;
            if (wr_issue) begin
                rc <= xfer_addr;
                wd <= xfer_data;
            end
            busy <= busy_next;
            if (xfer_valid && xfer_is_r0) begin
                r0_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of the write data.
REQ-002 Parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req0_valid  in  1  requester 0 (ALU writeback) has a write pending.
REQ-007 req0_addr  in  ADDR_W  destination register of requester 0.
REQ-008 req0_data  in  DATA_W  write data of requester 0.
REQ-009 req0_ready  out  1  requester 0 write accepted this cycle.
REQ-010 req1_valid, req1_addr, req1_data, req1_ready: same as REQ-006..009 for requester 1 (memory load).
REQ-011 rsv_valid  in  1  decode reserves a destination register.
REQ-012 rsv_addr  in  ADDR_W  register being reserved.
REQ-013 RegWrite  out  1  register-file write enable, registered.
REQ-014 rc  out  ADDR_W  register-file write address, registered.
REQ-015 wd  out  DATA_W  register-file write data, registered.
REQ-016 busy  out  2**ADDR_W  scoreboard; bit i = register i has an outstanding write.
REQ-017 r0_err  out  1  sticky flag; a write to register 0 was attempted.

Function
REQ-018 A transfer on port k SHALL occur in a cycle where reqk_valid and reqk_ready are both 1; reqk_ready SHALL be combinational from the valid inputs and the priority pointer.
REQ-019 At most one port SHALL be ready per cycle; with one valid, that port SHALL be ready the same cycle.
REQ-020 With both valid, the port named by the priority pointer SHALL be granted; the pointer SHALL then point to the other port.
REQ-021 The pointer SHALL change only on a contended grant; an uncontended grant SHALL leave it unchanged.
REQ-022 A transfer accepted in cycle N with addr != 0 SHALL drive RegWrite=1, rc=addr, wd=data in cycle N+1; with no transfer, RegWrite SHALL be 0 in the next cycle and rc/wd SHALL hold their values.
REQ-023 A transfer with addr == 0 SHALL be accepted (ready=1) but SHALL NOT assert RegWrite, and SHALL set r0_err, which stays 1 until reset.
REQ-024 rsv_valid with rsv_addr != 0 SHALL set busy[rsv_addr] at the next edge; rsv_addr == 0 SHALL be ignored; busy[0] SHALL be constantly 0.
REQ-025 A cycle with RegWrite=1 SHALL clear busy[rc] at the next edge.
REQ-026 Set and clear of the same bit in the same cycle: set SHALL win.
REQ-027 Reserving an already busy register SHALL leave it busy; no count is kept.
REQ-028 Both ports targeting the same register in one cycle SHALL be serialized in pointer order; the later write SHALL land one or more cycles after the earlier one.
REQ-029 Under continuous contention, grants SHALL alternate 0,1,0,1...; no port SHALL wait more than one cycle.

Reset
REQ-030 While rst=1: RegWrite=0, rc=0, wd=0, busy=0, r0_err=0, pointer=port 0; both ready outputs are 0.
REQ-031 A request presented during reset SHALL NOT be accepted; requesters re-present after reset; no write issued before reset SHALL reappear after it.

Structure
REQ-032 A shared package regfile_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS and the constant R0_ADDR=0, shared with the register file and the control unit.
REQ-033 The two-port round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs: two requests and the pointer; outputs: one-hot grant and the next pointer); scoreboard and output registers live in the top module.

Verification
REQ-034 After reset, req0 addr=3 data=16'hABCD only -> req0_ready=1 same cycle; next cycle RegWrite=1, rc=3, wd=16'hABCD; the cycle after, RegWrite=0.
REQ-035 Both valid for 4 cycles (req0 addr=1, req1 addr=2) right after reset -> grants 0,1,0,1; writes rc=1,2,1,2 on consecutive cycles.
REQ-036 req1 addr=0 data=16'h1234 -> req1_ready=1, RegWrite stays 0, r0_err=1 and stays 1 until rst.
REQ-037 rsv addr=5 -> busy=8'h20; write to 5 -> busy=0 one cycle after RegWrite; reserve 5 in the same cycle RegWrite=1, rc=5 -> busy stays 8'h20.
REQ-038 rsv addr=0 -> busy stays 0; rst pulsed mid-contention with busy=8'h06 -> outputs 0, busy=0, pointer=0; first contended grant after reset goes to port 0.
